// File: rtl/clock_set_pkg.sv
// Shared types and constants for the time-set controller: FSM state encoding,
// button indices and the width of every tick counter in the block.
package clock_set_pkg;

  localparam int TICK_CNT_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_PEND     = 2'd1;
  localparam state_t ST_HOLD     = 2'd2;
  localparam state_t ST_WAIT_REL = 2'd3;

  typedef logic [1:0] btn_idx_t;
  localparam btn_idx_t BTN_SS = 2'd0;
  localparam btn_idx_t BTN_HH = 2'd1;
  localparam btn_idx_t BTN_MM = 2'd2;

  // Fixed arbitration order: seconds-clear wins, then hours, then minutes.
  function automatic btn_idx_t pick_btn(input logic [2:0] lvl);
    if (lvl[BTN_SS]) return BTN_SS;
    if (lvl[BTN_HH]) return BTN_HH;
    return BTN_MM;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/command bundle between the time-set controller (slave) and the
// surrounding clock design or a testbench (master).
interface clock_set_ctrl_if;
  logic tick;
  logic btn_hh;
  logic btn_mm;
  logic btn_ss;
  logic carry_busy;
  logic inc_h;
  logic inc_m;
  logic clr_s;
  logic set_active;

  modport master (
    output tick, btn_hh, btn_mm, btn_ss, carry_busy,
    input  inc_h, inc_m, clr_s, set_active
  );

  modport slave (
    input  tick, btn_hh, btn_mm, btn_ss, carry_busy,
    output inc_h, inc_m, clr_s, set_active
  );
endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// One button: 2-flop synchronizer followed by a tick-sampled debouncer whose
// level flips after DEBOUNCE_TICKS consecutive disagreeing samples.
module btn_debounce
  import clock_set_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic level
);

  localparam logic [TICK_CNT_W-1:0] CNT_MAX = TICK_CNT_W'(DEBOUNCE_TICKS);
  localparam logic [TICK_CNT_W-1:0] CNT_ONE = TICK_CNT_W'(1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  level_q, level_d;
  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
  logic [TICK_CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any agreeing sample restarts the run, so only an unbroken run flips.
    if (tick) begin
      if (sync2_q != level_q) begin
        if (cnt_inc == CNT_MAX) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounces three buttons, services one at a time and
// issues carry-safe command strobes. Auto-repeat needs CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 16,
  parameter int REPEAT_RATE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  clock_set_ctrl_if.slave  bus
);

  logic [2:0] lvl;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_ss (
    .clk(clk), .rst(rst), .tick(bus.tick), .btn_raw(bus.btn_ss), .level(lvl[BTN_SS])
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_hh (
    .clk(clk), .rst(rst), .tick(bus.tick), .btn_raw(bus.btn_hh), .level(lvl[BTN_HH])
  );
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mm (
    .clk(clk), .rst(rst), .tick(bus.tick), .btn_raw(bus.btn_mm), .level(lvl[BTN_MM])
  );

  state_t   state_q, state_d;
  btn_idx_t sel_q, sel_d;
  logic     inc_h_q, inc_h_d;
  logic     inc_m_q, inc_m_d;
  logic     clr_s_q, clr_s_d;
  logic     sel_lvl;

  assign sel_lvl = lvl[sel_q];

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam logic [TICK_CNT_W-1:0] DELAY_LD = TICK_CNT_W'(REPEAT_DELAY);
  localparam logic [TICK_CNT_W-1:0] RATE_LD  = TICK_CNT_W'(REPEAT_RATE);
  localparam logic [TICK_CNT_W-1:0] HOLD_ONE = TICK_CNT_W'(1);

  logic [TICK_CNT_W-1:0] hold_q, hold_d;
  logic [TICK_CNT_W-1:0] hold_dec;
  logic                  rpt_q, rpt_d;

  assign hold_dec = (hold_q == '0) ? '0 : hold_q - HOLD_ONE;
`else
  logic [TICK_CNT_W-1:0] unused_repeat_cfg;
  assign unused_repeat_cfg = TICK_CNT_W'(REPEAT_DELAY ^ REPEAT_RATE);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inc_h_d = 1'b0;
    inc_m_d = 1'b0;
    clr_s_d = 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    hold_d  = hold_q;
    rpt_d   = rpt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|lvl) begin
          sel_d   = pick_btn(lvl);
          state_d = ST_PEND;
        end
      end
      // Strobe launches on the first edge with no carry imminent.
      ST_PEND: begin
        if (!bus.carry_busy) begin
          inc_h_d = (sel_q == BTN_HH);
          inc_m_d = (sel_q == BTN_MM);
          clr_s_d = (sel_q == BTN_SS);
`ifdef CLOCK_SET_AUTOREPEAT_EN
          hold_d  = rpt_q ? RATE_LD : DELAY_LD;
`endif
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!sel_lvl) begin
          state_d = ST_WAIT_REL;
        end
`ifdef CLOCK_SET_AUTOREPEAT_EN
        else if (bus.tick && (sel_q != BTN_SS)) begin
          hold_d = hold_dec;
          if (hold_dec == '0) begin
            state_d = ST_PEND;
            rpt_d   = 1'b1;
          end
        end
`endif
      end
      ST_WAIT_REL: begin
        if (~|lvl) begin
          state_d = ST_IDLE;
`ifdef CLOCK_SET_AUTOREPEAT_EN
          rpt_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= BTN_SS;
      inc_h_q <= 1'b0;
      inc_m_q <= 1'b0;
      clr_s_q <= 1'b0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      hold_q  <= '0;
      rpt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      inc_h_q <= inc_h_d;
      inc_m_q <= inc_m_d;
      clr_s_q <= clr_s_d;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign bus.inc_h      = inc_h_q;
  assign bus.inc_m      = inc_m_q;
  assign bus.clr_s      = clr_s_q;
  assign bus.set_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: scenario table, hand-written carry/reset sequences
// and randomized buttons, all checked every cycle against a reference model.
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RR = 4;
`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_set_ctrl_if ifc ();

  clock_set_ctrl #(.DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int cyc_no = 0;
  int last_strobe = -100;
  int n_h, n_m, n_s;
  bit seen_active;

  // Reference model: button index 0=ss, 1=hh, 2=mm.
  // phase 0 idle, 1 waiting to fire, 2 holding, 3 waiting for release.
  bit s1[3], s2[3], dl[3];
  int dc[3];
  int phase = 0, owner = 0, hold = 0;
  bit rpt = 0;
  bit e_h, e_m, e_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc_no, act, exp);
    end
  endtask

  task automatic model_step();
    bit raw[3];
    bit any;
    raw[0] = ifc.btn_ss; raw[1] = ifc.btn_hh; raw[2] = ifc.btn_mm;
    e_h = 0; e_m = 0; e_s = 0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin s1[i] = 0; s2[i] = 0; dl[i] = 0; dc[i] = 0; end
      phase = 0; owner = 0; hold = 0; rpt = 0;
      return;
    end
    any = dl[0] | dl[1] | dl[2];
    case (phase)
      0: if (any) begin owner = dl[0] ? 0 : (dl[1] ? 1 : 2); phase = 1; end
      1: if (!ifc.carry_busy) begin
           e_s = (owner == 0); e_h = (owner == 1); e_m = (owner == 2);
           hold = rpt ? RR : RD;
           phase = 2;
         end
      2: if (!dl[owner]) phase = 3;
         else if (AR && owner != 0 && ifc.tick) begin
           hold = (hold > 0) ? hold - 1 : 0;
           if (hold == 0) begin phase = 1; rpt = 1; end
         end
      default: if (!any) begin phase = 0; rpt = 0; end
    endcase
    for (int i = 0; i < 3; i++) begin
      if (ifc.tick) begin
        if (s2[i] != dl[i]) begin
          dc[i]++;
          if (dc[i] == DB) begin dl[i] = !dl[i]; dc[i] = 0; end
        end else dc[i] = 0;
      end
      s2[i] = s1[i];
      s1[i] = raw[i];
    end
  endtask

  task automatic cyc();
    int nstb;
    ifc.tick = (tick_cnt % 4 == 0);
    tick_cnt++;
    @(posedge clk);
    model_step();
    #1;
    check("inc_h", ifc.inc_h, e_h);
    check("inc_m", ifc.inc_m, e_m);
    check("clr_s", ifc.clr_s, e_s);
    check("set_active", ifc.set_active, (phase != 0));
    nstb = int'(ifc.inc_h) + int'(ifc.inc_m) + int'(ifc.clr_s);
    check("one_strobe", (nstb <= 1), 1);
    if (nstb > 0) begin
      check("strobe_gap", ((cyc_no - last_strobe) >= 2), 1);
      last_strobe = cyc_no;
    end
    n_h += int'(ifc.inc_h);
    n_m += int'(ifc.inc_m);
    n_s += int'(ifc.clr_s);
    if (ifc.set_active === 1'b1) seen_active = 1;
    cyc_no++;
  endtask

  task automatic set_btn(input bit [2:0] m);
    ifc.btn_ss = m[0];
    ifc.btn_hh = m[1];
    ifc.btn_mm = m[2];
  endtask

  task automatic clear_counts();
    n_h = 0; n_m = 0; n_s = 0; seen_active = 0;
  endtask

  typedef struct {
    bit [2:0] btn;      // [0]=ss [1]=hh [2]=mm
    int       ticks;    // raw press length in ticks
    int       exp_h;
    int       exp_m;
    int       exp_s;
    bit       exp_active;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit found;
    int lat;
    vecs[0] = '{3'b100,  3, 0, 0, 0, 1'b0};        // too short to debounce
    vecs[1] = '{3'b100, 10, 0, 1, 0, 1'b1};        // single minute press
    vecs[2] = '{3'b010, 30, AR ? 5 : 1, 0, 0, 1'b1}; // hours held: repeats at 16,20,24,28
    vecs[3] = '{3'b001, 30, 0, 0, 1, 1'b1};        // seconds-clear never repeats
    vecs[4] = '{3'b011, 10, 0, 0, 1, 1'b1};        // simultaneous: ss wins, hh dropped
    vecs[5] = '{3'b010, 10, 1, 0, 0, 1'b1};        // hh serviced on a fresh press

    rst = 1'b1;
    ifc.carry_busy = 1'b0;
    set_btn(3'b000);
    clear_counts();
    repeat (3) cyc();
    check("reset_inc_h", ifc.inc_h, 0);
    check("reset_inc_m", ifc.inc_m, 0);
    check("reset_clr_s", ifc.clr_s, 0);
    check("reset_set_active", ifc.set_active, 0);
    rst = 1'b0;
    repeat (8) cyc();

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      set_btn(vecs[i].btn);
      repeat (vecs[i].ticks * 4) cyc();
      set_btn(3'b000);
      repeat (40) cyc();
      check($sformatf("vec%0d_inc_h_count", i), n_h, vecs[i].exp_h);
      check($sformatf("vec%0d_inc_m_count", i), n_m, vecs[i].exp_m);
      check($sformatf("vec%0d_clr_s_count", i), n_s, vecs[i].exp_s);
      check($sformatf("vec%0d_active_seen", i), seen_active, vecs[i].exp_active);
      check($sformatf("vec%0d_idle_after", i), ifc.set_active, 0);
    end

    // Carry hold-off spanning the strobe point.
    clear_counts();
    set_btn(3'b100);
    repeat (12) cyc();
    ifc.carry_busy = 1'b1;
    repeat (10) cyc();
    check("carry_no_strobe_while_busy", n_m, 0);
    check("carry_pending_active", ifc.set_active, 1);
    ifc.carry_busy = 1'b0;
    cyc();
    check("carry_release_strobe", ifc.inc_m, 1);
    repeat (6) cyc();
    set_btn(3'b000);
    repeat (40) cyc();
    check("carry_single_strobe", n_m, 1);

    // Reset while holding minutes.
    clear_counts();
    set_btn(3'b100);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (ifc.inc_m === 1'b1) found = 1;
    end
    check("rst_first_strobe_found", found, 1);
    repeat (4) cyc();
    check("rst_in_hold_active", ifc.set_active, 1);
    rst = 1'b1;
    cyc();
    check("rst_cycle_outputs", {ifc.inc_h, ifc.inc_m, ifc.clr_s, ifc.set_active}, 0);
    rst = 1'b0;
    cyc();
    check("rst_next_outputs", {ifc.inc_h, ifc.inc_m, ifc.clr_s, ifc.set_active}, 0);
    found = 0;
    lat = 1;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc();
      lat++;
      if (ifc.inc_m === 1'b1) found = 1;
    end
    check("rst_reissue_found", found, 1);
    check("rst_reissue_after_full_debounce", (lat >= 16), 1);
    set_btn(3'b000);
    repeat (40) cyc();

    // Randomized buttons, carry and occasional reset.
    for (int seg = 0; seg < 80; seg++) begin
      bit [2:0] m;
      int len;
      m = 3'($urandom_range(0, 7));
      len = $urandom_range(4, 80);
      set_btn(m);
      for (int k = 0; k < len; k++) begin
        ifc.carry_busy = ($urandom_range(0, 9) < 2);
        rst = ($urandom_range(0, 299) == 0);
        cyc();
      end
    end
    rst = 1'b0;
    ifc.carry_busy = 1'b0;
    set_btn(3'b000);
    repeat (40) cyc();
    check("final_idle", ifc.set_active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
